// File: rtl/otter_crypto_pkg.sv
// Shared definitions for the OTTER ENCRY crypto unit.
//  - cry_state_t and its two FSM state constants (IDLE, RUN)
//  - RC round-constant table and the default rotate amount
//  - rotl32 / rotr32 rotate helpers and the round_key schedule function
package otter_crypto_pkg;

  typedef logic [0:0] cry_state_t;
  localparam cry_state_t IDLE = 1'b0;
  localparam cry_state_t RUN  = 1'b1;

  localparam int NROUND      = 4;
  localparam int ROT_DEFAULT = 7;

  localparam logic [7:0] RC [NROUND] = '{8'h1B, 8'h36, 8'h6C, 8'hD8};

  // A shift by 32 yields zero, so an amount of 0 returns v unchanged.
  function automatic logic [31:0] rotl32(input logic [31:0] v, input logic [4:0] s);
    return (v << s) | (v >> (6'd32 - {1'b0, s}));
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] v, input logic [4:0] s);
    return (v >> s) | (v << (6'd32 - {1'b0, s}));
  endfunction

  // k[r] = ROTL(key, 8r) ^ RC[r]
  function automatic logic [31:0] round_key(input logic [31:0] key, input logic [1:0] r);
    return rotl32(key, {r, 3'b000}) ^ {24'h0, RC[r]};
  endfunction

endpackage

// File: rtl/otter_crypto_round.sv
// One combinational cipher round.
//  x    in   32  round input
//  k    in   32  round key (already scheduled)
//  mode in   1   0 = encrypt, 1 = decrypt
//  y    out  32  round output
//  Encrypt: y = ROTL(x ^ k, ROT) + k
//  Decrypt: y = ROTR(x - k, ROT) ^ k   (exact inverse of the encrypt round)
module otter_crypto_round
  import otter_crypto_pkg::*;
#(
  parameter int ROT = ROT_DEFAULT
) (
  input  logic [31:0] x,
  input  logic [31:0] k,
  input  logic        mode,
  output logic [31:0] y
);

  localparam logic [4:0] SH = 5'(ROT);

  always_comb begin
    if (!mode) begin
      y = rotl32(x ^ k, SH) + k;
    end else begin
      y = rotr32(x - k, SH) ^ k;
    end
  end

endmodule

// File: rtl/otter_crypto_unit.sv
// Multi-cycle 32-bit block cipher for the OTTER ENCRY opcode.
// Runs 4 rounds inside the CU's 4-cycle EXECUTE window; round 0 is done in
// the START cycle, rounds 1..2 are registered, round 3 is presented
// combinationally with DONE in the 4th cycle.
//  CRY_CLK      in   1   clock
//  CRY_RESET_N  in   1   asynchronous active-low reset
//  CRY_START    in   1   start pulse (first ENCRY EXECUTE cycle)
//  CRY_FLUSH    in   1   synchronous abort, highest priority
//  CRY_FUNC3    in   3   bit0 selects encrypt(0)/decrypt(1); others ignored
//  CRY_DATA     in   32  plaintext/ciphertext, sampled with START
//  CRY_KEY      in   32  key, sampled with START
//  CRY_RESULT   out  32  final round output while DONE, else last result
//  CRY_DONE     out  1   final-round cycle
//  CRY_BUSY     out  1   state == RUN
//  CRY_ROUND    out  2   current round index (tracks CU crypto_count)
//  CRY_OVERRUN  out  1   START seen while BUSY (that START is dropped)
module otter_crypto_unit
  import otter_crypto_pkg::*;
#(
  parameter int ROT = ROT_DEFAULT
) (
  input  logic        CRY_CLK,
  input  logic        CRY_RESET_N,
  input  logic        CRY_START,
  input  logic        CRY_FLUSH,
  input  logic [2:0]  CRY_FUNC3,
  input  logic [31:0] CRY_DATA,
  input  logic [31:0] CRY_KEY,
  output logic [31:0] CRY_RESULT,
  output logic        CRY_DONE,
  output logic        CRY_BUSY,
  output logic [1:0]  CRY_ROUND,
  output logic        CRY_OVERRUN
);

  cry_state_t  state_q;
  logic [1:0]  round_q;
  logic [31:0] x_q;
  logic [31:0] key_q;
  logic        mode_q;
  logic [31:0] last_q;

  logic        run;
  logic [31:0] rnd_x;
  logic [31:0] rnd_key;
  logic        rnd_mode;
  logic [1:0]  key_idx;
  logic [31:0] rnd_k;
  logic [31:0] rnd_y;
  logic        func3_unused;

  assign func3_unused = ^CRY_FUNC3[2:1];
  assign run = (state_q == RUN);

  // Single round datapath: IDLE feeds it straight from the operand ports so
  // round 0 completes in the START cycle; RUN feeds it from the registers.
  always_comb begin
    if (run) begin
      rnd_x    = x_q;
      rnd_key  = key_q;
      rnd_mode = mode_q;
    end else begin
      rnd_x    = CRY_DATA;
      rnd_key  = CRY_KEY;
      rnd_mode = CRY_FUNC3[0];
    end
    // Decrypt walks the key schedule backwards.
    key_idx = rnd_mode ? (2'd3 - round_q) : round_q;
    rnd_k   = round_key(rnd_key, key_idx);
  end

  otter_crypto_round #(
    .ROT (ROT)
  ) u_round (
    .x    (rnd_x),
    .k    (rnd_k),
    .mode (rnd_mode),
    .y    (rnd_y)
  );

  always_ff @(posedge CRY_CLK or negedge CRY_RESET_N) begin
    if (!CRY_RESET_N) begin
      state_q <= IDLE;
      round_q <= 2'd0;
      x_q     <= 32'd0;
      key_q   <= 32'd0;
      mode_q  <= 1'b0;
      last_q  <= 32'd0;
    end else if (CRY_FLUSH) begin
      // Abort discards the in-flight op but keeps the last good result.
      state_q <= IDLE;
      round_q <= 2'd0;
    end else if (!run) begin
      if (CRY_START) begin
        x_q     <= rnd_y;
        key_q   <= CRY_KEY;
        mode_q  <= CRY_FUNC3[0];
        round_q <= 2'd1;
        state_q <= RUN;
      end
    end else if (round_q == 2'd3) begin
      last_q  <= rnd_y;
      round_q <= 2'd0;
      state_q <= IDLE;
    end else begin
      x_q     <= rnd_y;
      round_q <= round_q + 2'd1;
    end
  end

  assign CRY_DONE    = run && (round_q == 2'd3) && !CRY_FLUSH;
  assign CRY_RESULT  = CRY_DONE ? rnd_y : last_q;
  assign CRY_BUSY    = run;
  assign CRY_ROUND   = round_q;
  assign CRY_OVERRUN = CRY_START && run && !CRY_FLUSH;

endmodule
